// File: rtl/serializer_pkg.sv
// Shared definitions for the LSB-first word serializer: FSM state encoding
// and the default data width.
package serializer_pkg;

    localparam int DEFAULT_N = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage : serializer_pkg

// File: rtl/serializer_bitcnt.sv
// Bit counter for the serializer: cleared at the start of a word, stepped once
// per shifted bit, and flags the final data bit.
module serializer_bitcnt
    import serializer_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic clk,
    input  logic clr_n,
    input  logic clear,
    input  logic inc,
    output logic last
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != CW'(N))) begin
            // Saturates at N so a stray extra increment can never wrap to 0.
            count_q <= count_q + CW'(1);
        end
    end

    assign last = (count_q == CW'(N - 1));

endmodule : serializer_bitcnt

// File: rtl/shift_serializer_10bit.sv
// Parallel-to-serial converter with valid/ready load handshake, LSB first.
// Define SERIALIZER_PARITY_EN to append one even-parity bit after the data.
module shift_serializer_10bit
    import serializer_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         sclr,
    input  logic [N-1:0] data_in,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         busy,
    output logic         done
);

    state_e       state_q;
    logic [N-1:0] shift_q;
    logic         cnt_last;
    logic         handshake;
`ifdef SERIALIZER_PARITY_EN
    logic         parity_q;
`endif

    assign handshake = load_valid && load_ready;

    serializer_bitcnt #(.N(N)) u_bitcnt (
        .clk   (clk),
        .clr_n (clr_n),
        .clear (sclr || handshake),
        .inc   (state_q == SHIFT),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
`ifdef SERIALIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (sclr) begin
            state_q  <= IDLE;
            shift_q  <= '0;
`ifdef SERIALIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        shift_q  <= data_in;
`ifdef SERIALIZER_PARITY_EN
                        parity_q <= ^data_in;
`endif
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_q <= {1'b0, shift_q[N-1:1]};
                    if (cnt_last) begin
`ifdef SERIALIZER_PARITY_EN
                        state_q <= PAR;
`else
                        state_q <= DONE;
`endif
                    end
                end
`ifdef SERIALIZER_PARITY_EN
                PAR:     state_q <= DONE;
`endif
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: outputs decode only registered state, so an asynchronous reset
    // shows its output values at once and no input reaches an output.
    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
`ifdef SERIALIZER_PARITY_EN
    assign ser_valid  = (state_q == SHIFT) || (state_q == PAR);
    assign ser_out    = ((state_q == SHIFT) && shift_q[0]) ||
                        ((state_q == PAR) && parity_q);
`else
    assign ser_valid  = (state_q == SHIFT);
    assign ser_out    = (state_q == SHIFT) && shift_q[0];
`endif

endmodule : shift_serializer_10bit

// File: tb/tb_shift_serializer_10bit.sv
// Directed bench for shift_serializer_10bit; follows SERIALIZER_PARITY_EN to
// expect or skip the parity bit.
module tb_shift_serializer_10bit;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       sclr;
    logic [9:0] data_in;
    logic       load_valid;
    logic       load_ready;
    logic       ser_out;
    logic       ser_valid;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    shift_serializer_10bit #(.N(10)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .sclr       (sclr),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".load_ready"}, 32'(load_ready), 32'd1);
        check({tag, ".busy"},       32'(busy),       32'd0);
        check({tag, ".ser_valid"},  32'(ser_valid),  32'd0);
        check({tag, ".ser_out"},    32'(ser_out),    32'd0);
        check({tag, ".done"},       32'(done),       32'd0);
    endtask

    // Handshake at edge k, check the stream in cycles k+1.., the optional
    // parity bit, the done pulse, then return sampling the following IDLE cycle.
    // exp_bits lists the expected stream, first-sent bit in position 0.
    task automatic xfer(input string tag, input logic [9:0] d, input logic [9:0] exp_bits,
                        input logic exp_par, input bit hold, input logic [9:0] hold_data);
        @(negedge clk);
        check({tag, ".ready_before"}, 32'(load_ready), 32'd1);
        data_in    = d;
        load_valid = 1'b1;
        @(negedge clk);
        if (hold) data_in = hold_data;
        else      load_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("%s.bit%0d", tag, i), 32'({ser_valid, ser_out}), 32'({1'b1, exp_bits[i]}));
            check($sformatf("%s.busy%0d", tag, i), 32'({busy, load_ready, done}), 32'b100);
            @(negedge clk);
        end
`ifdef SERIALIZER_PARITY_EN
        check({tag, ".parity"}, 32'({ser_valid, ser_out, done}), 32'({1'b1, exp_par, 1'b0}));
        @(negedge clk);
`else
        if (exp_par === 1'bx) $display("note: parity argument unused");
`endif
        check({tag, ".done_cycle"}, 32'({done, busy, ser_valid, load_ready}), 32'b1100);
        @(negedge clk);
        check({tag, ".after_done"}, 32'({done, busy, load_ready}), 32'b001);
    endtask

    initial begin
        int done_seen;
        int busy_seen;

        clr_n      = 1'b0;
        sclr       = 1'b0;
        data_in    = '0;
        load_valid = 1'b0;

        #2;
        check_idle("reset");
        #10 clr_n = 1'b1;

        // Word 2A5: stream 1,0,1,0,0,1,0,1,0,1 and even parity 1.
        xfer("w2a5", 10'h2A5, 10'b1010100101, 1'b1, 1'b0, 10'h000);

        // 001 while load_valid stays high with 3FF: the stream is unaffected and
        // the next word is captured only from the IDLE that follows DONE.
        xfer("w001", 10'h001, 10'b0000000001, 1'b1, 1'b1, 10'h3FF);
        @(negedge clk);                               // cycle k'+1 of the 3FF word
        load_valid = 1'b0;
        check("hold.next_started", 32'({busy, ser_valid, ser_out}), 32'b111);
        @(negedge clk);
        check("hold.bit1", 32'(ser_out), 32'd1);
        @(negedge clk);
        check("hold.bit2", 32'(ser_out), 32'd1);
        @(negedge clk);                               // cycle k'+4: sclr pulse
        sclr       = 1'b1;
        load_valid = 1'b1;
        data_in    = 10'h0F0;
        @(negedge clk);
        sclr       = 1'b0;
        load_valid = 1'b0;
        check_idle("sclr_abort");
        done_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            done_seen += int'(done);
            busy_seen += int'(busy);
        end
        check("sclr.no_done", 32'(done_seen), 32'd0);
        check("sclr.stays_idle", 32'(busy_seen), 32'd0);

        // sclr together with a valid word in IDLE must not capture it.
        sclr       = 1'b1;
        load_valid = 1'b1;
        data_in    = 10'h2A5;
        @(negedge clk);
        sclr       = 1'b0;
        load_valid = 1'b0;
        check_idle("sclr_vs_load");

        // Asynchronous reset in the middle of a word.
        data_in    = 10'h3C3;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        check("pre_rst.shifting", 32'({busy, ser_valid, ser_out}), 32'b111);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst.bit2", 32'({busy, ser_out}), 32'b10);
        #2 clr_n = 1'b0;
        #1 check_idle("async_rst");
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            done_seen += int'(done);
        end
        check("rst.no_done", 32'(done_seen), 32'd0);
        @(posedge clk);
        #2 clr_n = 1'b1;

        // First edge after release takes the handshake.
        xfer("w155", 10'h155, 10'b0101010101, 1'b1, 1'b0, 10'h000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_shift_serializer_10bit
